uart_receiver: RTL and testbench

//   Serial-to-memory stage that terminates the UART link driven by uart_sender.

---
 rtl/uart_receiver.sv | 150 +++++++++++++++
 tb/tb_uart_receiver.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART 8N1 receiver that packs WORD_BYTES bytes, first byte most significant, into one word.
// Each completed word is written out with an address that increments after every write.
module uart_receiver #(
    parameter int                OVERSAMPLE = 16,
    parameter int                WORD_BYTES = 4,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_rx,
    input  logic                    i_clear,
    output logic                    o_wr_en,
    output logic [ADDR_W-1:0]       o_wr_addr,
    output logic [8*WORD_BYTES-1:0] o_wr_data,
    output logic                    o_frame_err,
    output logic                    o_busy
);

    localparam int PH_W   = $clog2(OVERSAMPLE);
    localparam int CNT_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int WORD_W = 8 * WORD_BYTES;

    localparam logic [PH_W-1:0]  PH_MID   = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [2:0]         bit_cnt_q;
    logic [7:0]         shift_q;
    logic [CNT_W-1:0]   byte_cnt_q;
    logic [WORD_W-1:0]  word_q;
    logic [WORD_W-1:0]  word_next;
    logic               rx_meta, rxs, rxs_prev;
    logic               rx_fall;
    logic               bit_sample, stop_sample, byte_ok, byte_bad;

    // Idle level is 1 so that reset never looks like a start edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make these three flops a true shift chain;
            // blocking ones would collapse them into a single stage.
            rx_meta  <= i_rx;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    assign rx_fall = rxs_prev & ~rxs;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d = state_q;
        phase_d = '0;
        case (state_q)
            S_IDLE:  if (rx_fall) state_d = S_START;
            S_START: if (phase_q == PH_MID) state_d = rxs ? S_IDLE : S_DATA;
            S_DATA:  if (phase_q == PH_LAST && bit_cnt_q == 3'd7) state_d = S_STOP;
            S_STOP:  if (phase_q == PH_LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (i_clear) state_d = S_IDLE;
        // The phase restarts on every state change and wraps once per bit while in DATA.
        if (state_d == state_q && state_q != S_IDLE && phase_q != PH_LAST)
            phase_d = phase_q + PH_W'(1);
    end

    assign bit_sample  = (state_q == S_DATA) && (phase_q == PH_LAST);
    assign stop_sample = (state_q == S_STOP) && (phase_q == PH_LAST);
    assign byte_ok     = stop_sample & rxs;
    assign byte_bad    = stop_sample & ~rxs;
    assign o_busy      = (state_q != S_IDLE);

    always_comb begin
        word_next      = word_q << 8;
        word_next[7:0] = shift_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: the word and output registers are reset because their values are
            // visible on the ports, which must read 0 after reset.
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            o_wr_en     <= 1'b0;
            o_wr_addr   <= BASE_ADDR;
            o_wr_data   <= '0;
            o_frame_err <= 1'b0;
        end else begin
            if (state_q == S_START)
                bit_cnt_q <= '0;
            else if (bit_sample)
                bit_cnt_q <= bit_cnt_q + 3'd1;

            if (bit_sample)
                shift_q <= {rxs, shift_q[7:1]};

            // Clear has priority over everything else, including a write that is due.
            if (i_clear) begin
                byte_cnt_q  <= '0;
                o_wr_en     <= 1'b0;
                o_wr_addr   <= BASE_ADDR;
                o_frame_err <= 1'b0;
            end else begin
                o_wr_en     <= 1'b0;
                o_frame_err <= 1'b0;
                if (o_wr_en)
                    o_wr_addr <= o_wr_addr + ADDR_W'(1);
                if (byte_bad) begin
                    o_frame_err <= 1'b1;
                    byte_cnt_q  <= '0;
                end else if (byte_ok) begin
                    word_q <= word_next;
                    if (byte_cnt_q == CNT_LAST) begin
                        byte_cnt_q <= '0;
                        o_wr_en    <= 1'b1;
                        o_wr_data  <= word_next;
                    end else begin
                        byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: bit-timed 8N1 stimulus feeds a write scoreboard.
// ADDR_W is 4, so the address wrap is reached with only 17 words.
module tb_uart_receiver;

    localparam int OS     = 16;
    localparam int AW     = 4;
    // Offset inside a byte (start bit at 0) of the cycle whose closing edge takes the stop-bit sample:
    // 2 synchroniser cycles, 1 cycle of edge detection, half a bit in START, then 9 full bits.
    localparam int CLR_AT = 2 + OS / 2 + 9 * OS;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_rx;
    logic          i_clear;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic [31:0]   o_wr_data;
    logic          o_frame_err;
    logic          o_busy;

    int   total  = 0;
    int   bad    = 0;
    int   wr_cnt = 0;
    int   fe_cnt = 0;
    logic busy_mid;
    wr_t  exp_q[$];
    wr_t  mon_e;

    uart_receiver #(
        .OVERSAMPLE(OS),
        .WORD_BYTES(4),
        .ADDR_W    (AW),
        .BASE_ADDR ('0)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_rx       (i_rx),
        .i_clear    (i_clear),
        .o_wr_en    (o_wr_en),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .o_frame_err(o_frame_err),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Scoreboard monitor: each write strobe pops one expected write and compares it.
    always @(negedge i_clk) begin
        if (o_frame_err === 1'b1) fe_cnt++;
        if (o_wr_en === 1'b1) begin
            wr_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%08h, none expected", o_wr_addr, o_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (o_wr_addr !== mon_e.addr || o_wr_data !== mon_e.data) begin
                    bad++;
                    $display("FAIL write: got addr=%0d data=%08h, want addr=%0d data=%08h",
                             o_wr_addr, o_wr_data, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic push_exp(input logic [AW-1:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        i_rx = 1'b1;
        repeat (n) @(negedge i_clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic clr_at_stop);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int c = 0; c < 10 * OS; c++) begin
            i_rx    = frame[c / OS];
            i_clear = clr_at_stop && (c == CLR_AT);
            if (c == 5 * OS) busy_mid = o_busy;
            @(negedge i_clk);
        end
        i_clear = 1'b0;
        i_rx    = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], 1'b1, 1'b0);
    endtask

    task automatic pulse_clear();
        i_clear = 1'b1;
        @(negedge i_clk);
        i_clear = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge i_clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d writes outstanding, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_rx    = 1'b1;
        i_clear = 1'b0;
        repeat (3) @(negedge i_clk);
        total += 5;
        if (o_wr_en !== 1'b0)     begin bad++; $display("FAIL reset_wr_en: got %b want 0", o_wr_en); end
        if (o_wr_addr !== '0)     begin bad++; $display("FAIL reset_addr: got %0d want 0", o_wr_addr); end
        if (o_wr_data !== '0)     begin bad++; $display("FAIL reset_data: got %08h want 0", o_wr_data); end
        if (o_frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", o_frame_err); end
        if (o_busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        i_rst_n = 1'b1;
        idle(10);
    endtask

    task automatic test_single_word();
        int fe0;
        fe0 = fe_cnt;
        push_exp(4'd0, 32'hDEADBEEF);
        send_word(32'hDEADBEEF);
        drain("single_word");
        idle(3);
        total += 2;
        if (o_wr_addr !== 4'd1) begin bad++; $display("FAIL single_addr_incr: got %0d want 1", o_wr_addr); end
        if (fe_cnt !== fe0)     begin bad++; $display("FAIL single_frame_err: got %0d want %0d", fe_cnt, fe0); end
    endtask

    task automatic test_two_words();
        pulse_clear();
        push_exp(4'd0, 32'h01020304);
        push_exp(4'd1, 32'hA5A55A5A);
        send_word(32'h01020304);
        total++;
        if (busy_mid !== 1'b1) begin bad++; $display("FAIL busy_mid_frame: got %b want 1", busy_mid); end
        idle(8);
        total++;
        if (o_busy !== 1'b0) begin bad++; $display("FAIL busy_in_gap: got %b want 0", o_busy); end
        idle(24);
        send_word(32'hA5A55A5A);
        drain("two_words");
        idle(3);
        total++;
        if (o_wr_addr !== 4'd2) begin bad++; $display("FAIL two_words_addr: got %0d want 2", o_wr_addr); end
    endtask

    task automatic test_glitch();
        int w0, fe0;
        logic seen_busy;
        w0  = wr_cnt;
        fe0 = fe_cnt;
        i_rx = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rx = 1'b1;
        repeat (3) @(negedge i_clk);
        seen_busy = o_busy;
        repeat (6) @(negedge i_clk);
        total += 4;
        if (seen_busy !== 1'b1) begin bad++; $display("FAIL glitch_start_seen: got busy=%b want 1", seen_busy); end
        if (o_busy !== 1'b0)    begin bad++; $display("FAIL glitch_back_idle: got busy=%b want 0", o_busy); end
        idle(40);
        if (wr_cnt !== w0)  begin bad++; $display("FAIL glitch_no_write: got %0d writes want %0d", wr_cnt, w0); end
        if (fe_cnt !== fe0) begin bad++; $display("FAIL glitch_no_frame_err: got %0d want %0d", fe_cnt, fe0); end
    endtask

    task automatic test_frame_error();
        int fe0;
        pulse_clear();
        fe0 = fe_cnt;
        push_exp(4'd0, 32'h11223344);
        send_byte(8'h77, 1'b1, 1'b0);
        send_byte(8'h99, 1'b0, 1'b0);
        idle(16);
        send_word(32'h11223344);
        drain("frame_error");
        idle(3);
        total++;
        if (fe_cnt !== fe0 + 1) begin bad++; $display("FAIL frame_err_count: got %0d want %0d", fe_cnt, fe0 + 1); end
    endtask

    task automatic test_clear_on_stop();
        int w0;
        w0 = wr_cnt;
        send_byte(8'hA1, 1'b1, 1'b0);
        send_byte(8'hA2, 1'b1, 1'b0);
        send_byte(8'hA3, 1'b1, 1'b0);
        send_byte(8'hA4, 1'b1, 1'b1);
        idle(4);
        total += 2;
        if (wr_cnt !== w0)      begin bad++; $display("FAIL clear_suppress_write: got %0d writes want %0d", wr_cnt, w0); end
        if (o_wr_addr !== 4'd0) begin bad++; $display("FAIL clear_addr: got %0d want 0", o_wr_addr); end
        push_exp(4'd0, 32'hCAFEF00D);
        send_word(32'hCAFEF00D);
        drain("after_clear");
    endtask

    task automatic test_reset_mid_byte();
        i_rx = 1'b0;
        repeat (40) @(negedge i_clk);
        total++;
        if (o_busy !== 1'b1) begin bad++; $display("FAIL mid_byte_busy: got %b want 1", o_busy); end
        i_rst_n = 1'b0;
        #1;
        total += 5;
        if (o_wr_en !== 1'b0)     begin bad++; $display("FAIL rst_mid_wr_en: got %b want 0", o_wr_en); end
        if (o_wr_addr !== '0)     begin bad++; $display("FAIL rst_mid_addr: got %0d want 0", o_wr_addr); end
        if (o_wr_data !== '0)     begin bad++; $display("FAIL rst_mid_data: got %08h want 0", o_wr_data); end
        if (o_frame_err !== 1'b0) begin bad++; $display("FAIL rst_mid_frame_err: got %b want 0", o_frame_err); end
        if (o_busy !== 1'b0)      begin bad++; $display("FAIL rst_mid_busy: got %b want 0", o_busy); end
        @(negedge i_clk);
        i_rx = 1'b1;
        repeat (4) @(negedge i_clk);
        i_rst_n = 1'b1;
        idle(20);
    endtask

    task automatic test_addr_wrap();
        logic [7:0]  ib;
        logic [31:0] w;
        for (int i = 0; i < 17; i++) begin
            ib = 8'(i);
            w  = {ib, ~ib, ib + 8'h40, ib ^ 8'h5A};
            push_exp(4'(i % 16), w);
            send_word(w);
        end
        drain("addr_wrap");
        idle(3);
        total++;
        if (o_wr_addr !== 4'd1) begin bad++; $display("FAIL wrap_final_addr: got %0d want 1", o_wr_addr); end
    endtask

    initial begin
        busy_mid = 1'b0;
        test_reset();
        test_single_word();
        test_two_words();
        test_glitch();
        test_frame_error();
        test_clear_on_stop();
        test_reset_mid_byte();
        test_addr_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
